// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; flush empties it and takes priority over push/pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push && (count != FULL);
    do_pop  = pop && (count != '0);
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs one-outstanding memory requests and feeds decode via a prefetch FIFO.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL       = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t      state;
  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   target_pc;
  logic [2*XLEN-1:0] head;

  always_comb begin
    push       = (state == WAIT) && imem_ack && !redirect;
    inst_valid = (count != '0);
    pop        = inst_valid && inst_ready;
    target_pc  = redirect_pc & ALIGN_MASK;
    inst       = head[2*XLEN-1:XLEN];
    inst_pc    = head[XLEN-1:0];
  end

  // imem_addr is its own register so it stays on the old address through DISCARD
  // while fetch_pc already tracks the redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      if (redirect) begin
        fetch_pc <= target_pc;
      end
      unique case (state)
        IDLE: begin
          if (!redirect && (count < FULL)) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
            if (!redirect) begin
              fetch_pc <= fetch_pc + STEP;
            end
          end else if (redirect) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_rdata, fetch_pc}),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: bench-side memory and decode sink, with an expected-PC stream model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  // second instance exercising a non-zero reset PC; left waiting on memory forever
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  inst_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .inst_valid(w_valid),
    .inst_ready(w_ready), .inst(w_inst), .inst_pc(w_pc),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // memory / sink state
  bit          pending;
  int unsigned wait_cnt;
  int unsigned lat;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] issued_q[$];
  int unsigned epoch = 0;
  logic [31:0] exp_pc;
  int unsigned n_pops;
  int unsigned base;
  int unsigned ready_mode;
  bit          rand_lat;
  int unsigned lat_fixed;
  bit          rand_redir;
  bit          force_redir;
  bit          redir_on_ack;
  logic [31:0] next_rpc;
  logic        coincide_valid;

  // Returned word depends on address and on the redirect epoch at request time,
  // so any word fetched before a redirect cannot match the post-redirect stream.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int unsigned ep);
    return (a * 32'h9E37_79B1) ^ (ep << 20) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    imem_rdata = '0; redirect_pc = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    pending = 1'b0; epoch++; exp_pc = 32'h0; n_pops = 0;
    issued_q.delete();
  endtask

  task automatic cycle();
    logic do_ack;
    if (imem_req && !pending) begin
      pending  = 1'b1;
      wait_cnt = 0;
      req_addr = imem_addr;
      req_data = mem_word(imem_addr, epoch);
      issued_q.push_back(imem_addr);
      lat = rand_lat ? $urandom_range(1, 4) : lat_fixed;
    end
    if (pending) begin
      check("req_held", {31'b0, imem_req}, 32'd1);
      check("addr_stable", imem_addr, req_addr);
    end
    do_ack     = pending && (wait_cnt >= lat);
    imem_ack   = do_ack;
    imem_rdata = do_ack ? req_data : $urandom;
    case (ready_mode)
      0:       inst_ready = 1'b0;
      1:       inst_ready = 1'b1;
      default: inst_ready = 1'($urandom_range(0, 1));
    endcase
    redirect    = 1'b0;
    redirect_pc = $urandom;
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = next_rpc; force_redir = 1'b0;
    end else if (redir_on_ack && do_ack) begin
      redirect = 1'b1; redirect_pc = next_rpc; inst_ready = 1'b1;
      coincide_valid = inst_valid; redir_on_ack = 1'b0;
    end else if (rand_redir && ($urandom_range(0, 15) == 0)) begin
      redirect = 1'b1;
    end
    if (inst_valid && inst_ready && !redirect) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst", inst, mem_word(exp_pc, epoch));
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
    if (redirect) begin
      epoch++;
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    @(posedge clk); #1;
    imem_ack = 1'b0;
    redirect = 1'b0;
    if (do_ack) begin
      pending = 1'b0;
      check("req_release", {31'b0, imem_req}, 32'd0);
    end else if (pending) begin
      wait_cnt++;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  initial begin
    w_ack = 1'b0; w_rdata = '0; w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
    rand_lat = 1'b0; lat_fixed = 2; rand_redir = 1'b0; ready_mode = 1;
    force_redir = 1'b0; redir_on_ack = 1'b0; next_rpc = '0; coincide_valid = 1'b0;

    // 1: reset state, then in-order fetch with 2-cycle memory latency
    do_reset();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("w_rst_req", {31'b0, w_req}, 32'd0);
    check("w_rst_addr", w_addr, 32'hFFFF_FFF8);
    check("w_rst_valid", {31'b0, w_valid}, 32'd0);
    check("w_rst_inst", w_inst, 32'h0);
    check("w_rst_pc", w_pc, 32'h0);
    lat_fixed = 2; ready_mode = 1;
    run(14);
    check("t1_issued", {31'b0, issued_q.size() >= 3}, 32'd1);
    for (int unsigned i = 0; i < 3; i++)
      check("t1_addr", (issued_q.size() > i) ? issued_q[i] : 32'hDEAD_BEEF, 32'(4 * i));
    check("t1_pops", {31'b0, n_pops >= 3}, 32'd1);
    check("w_first_req", {31'b0, w_req}, 32'd1);
    check("w_first_addr", w_addr, 32'hFFFF_FFF8);

    // 2: decode stalled, FIFO fills to 4, one pop frees one slot
    do_reset();
    lat_fixed = 1; ready_mode = 0;
    run(30);
    check("t2_issued", issued_q.size(), 32'd4);
    check("t2_req_idle", {31'b0, imem_req}, 32'd0);
    check("t2_valid", {31'b0, inst_valid}, 32'd1);
    check("t2_head_pc", inst_pc, exp_pc);
    ready_mode = 1;
    run(1);
    ready_mode = 0;
    run(10);
    check("t2_issued_after_pop", issued_q.size(), 32'd5);
    check("t2_addr16", (issued_q.size() >= 5) ? issued_q[4] : 32'hDEAD_BEEF, 32'd16);
    check("t2_head_after", inst_pc, 32'd4);

    // 3: redirect while a request is outstanding
    do_reset();
    lat_fixed = 6; ready_mode = 0;
    for (int unsigned i = 0; i < 10 && !pending; i++) cycle();
    check("t3_pending", {31'b0, pending}, 32'd1);
    run(1);
    force_redir = 1'b1; next_rpc = 32'h100;
    run(1);
    check("t3_discard_req", {31'b0, imem_req}, 32'd1);
    check("t3_discard_addr", imem_addr, 32'h0);
    check("t3_valid", {31'b0, inst_valid}, 32'd0);
    for (int unsigned i = 0; i < 40 && issued_q.size() < 2; i++) cycle();
    check("t3_new_req", (issued_q.size() >= 2) ? issued_q[1] : 32'hDEAD_BEEF, 32'h100);
    check("t3_valid_wait", {31'b0, inst_valid}, 32'd0);
    base = n_pops; ready_mode = 1; lat_fixed = 1;
    run(16);
    check("t3_popped", {31'b0, n_pops > base}, 32'd1);

    // 4: redirect coincident with ack and pop
    do_reset();
    lat_fixed = 3; ready_mode = 0;
    for (int unsigned i = 0; i < 30 && issued_q.size() < 2; i++) cycle();
    redir_on_ack = 1'b1; next_rpc = 32'h200; coincide_valid = 1'b0;
    for (int unsigned i = 0; i < 20 && redir_on_ack; i++) cycle();
    check("t4_coincide", {31'b0, coincide_valid}, 32'd1);
    check("t4_flushed", {31'b0, inst_valid}, 32'd0);
    for (int unsigned i = 0; i < 20 && issued_q.size() < 3; i++) cycle();
    check("t4_new_req", (issued_q.size() >= 3) ? issued_q[2] : 32'hDEAD_BEEF, 32'h200);
    base = n_pops; ready_mode = 1;
    run(12);
    check("t4_popped", {31'b0, n_pops > base}, 32'd1);

    // 5: PC wrap and redirect alignment
    do_reset();
    lat_fixed = 1; ready_mode = 1;
    force_redir = 1'b1; next_rpc = 32'hFFFF_FFF8;
    run(12);
    check("t5_a0", (issued_q.size() > 0) ? issued_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    check("t5_a1", (issued_q.size() > 1) ? issued_q[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("t5_a2", (issued_q.size() > 2) ? issued_q[2] : 32'hDEAD_BEEF, 32'h0);
    force_redir = 1'b1; next_rpc = 32'h103;
    run(1);
    base = issued_q.size();
    for (int unsigned i = 0; i < 20 && issued_q.size() <= base; i++) cycle();
    check("t5_aligned", (issued_q.size() > base) ? issued_q[base] : 32'hDEAD_BEEF, 32'h100);
    run(8);

    // 6: reset mid-request, stray ack afterwards
    do_reset();
    lat_fixed = 5; ready_mode = 1;
    for (int unsigned i = 0; i < 10 && !pending; i++) cycle();
    run(1);
    rst = 1'b1; imem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; pending = 1'b0; epoch++; exp_pc = 32'h0;
    check("t6_req", {31'b0, imem_req}, 32'd0);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_valid", {31'b0, inst_valid}, 32'd0);
    check("t6_inst", inst, 32'h0);
    check("t6_inst_pc", inst_pc, 32'h0);
    imem_ack = 1'b1; imem_rdata = $urandom;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    check("t6_stray_req", {31'b0, imem_req}, 32'd1);
    check("t6_stray_addr", imem_addr, 32'h0);
    check("t6_stray_valid", {31'b0, inst_valid}, 32'd0);
    base = n_pops;
    run(12);
    check("t6_popped", {31'b0, n_pops > base}, 32'd1);

    // random latency, backpressure and redirects against the stream model
    do_reset();
    rand_lat = 1'b1; ready_mode = 2; rand_redir = 1'b1;
    run(3000);
    check("rand_progress", {31'b0, n_pops >= 50}, 32'd1);
    rand_redir = 1'b0; ready_mode = 1;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
